// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter
// Shares the single-port Baby store RAM between the Manchester Baby core and
// the SPI RAM interface. Every access runs through IDLE -> ACCESS -> RESP and
// read data comes back registered. The Baby has priority while running, SPI
// while the Baby is halted, and a starvation counter stops a running Baby
// from locking SPI out indefinitely.
//
// Handshake (both requesters): a requester raises req with we/addr/data
// stable and holds them until it sees its gnt pulse. gnt is high for exactly
// one cycle, the cycle the access is on the RAM. The requester may drop req,
// or present a new request, from the cycle after gnt. Dropping req before
// gnt withdraws the request with no side effect. For reads, rvalid pulses for
// one cycle two cycles after gnt, and data_o then holds that word until the
// next read for the same requester. Writes never produce rvalid; gnt is the
// write acknowledge.

module shared_ram_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              sys_clock_i,
  input  logic              rst_i,
  input  logic              baby_halt_i,
  input  logic              baby_req_i,
  input  logic              baby_we_i,
  input  logic [ADDR_W-1:0] baby_addr_i,
  input  logic [DATA_W-1:0] baby_data_i,
  output logic              baby_gnt_o,
  output logic              baby_rvalid_o,
  output logic [DATA_W-1:0] baby_data_o,
  input  logic              spi_req_i,
  input  logic              spi_we_i,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [DATA_W-1:0] spi_data_i,
  output logic              spi_gnt_o,
  output logic              spi_rvalid_o,
  output logic [DATA_W-1:0] spi_data_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_BABY = 1'b0,
    OWN_SPI  = 1'b1
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [3:0] STARVE_MAX = 4'd15;

  state_t            state_q;
  owner_t            owner_q;
  logic              we_q;
  logic [3:0]        starve_cnt;

  logic              any_req;
  logic              spi_wins;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign dbg_state_o = state_q;

  // Arbitration decision and the winner's transaction fields, used only at
  // arbitration points (IDLE and RESP).
  always_comb begin
    any_req  = baby_req_i | spi_req_i;
    spi_wins = spi_req_i & (~baby_req_i | baby_halt_i | (starve_cnt >= STARVE_LIM));
    sel_we   = spi_wins ? spi_we_i   : baby_we_i;
    sel_addr = spi_wins ? spi_addr_i : baby_addr_i;
    sel_data = spi_wins ? spi_data_i : baby_data_i;
  end

  // Access sequencer: arbitrates, launches the RAM access with registered
  // outputs, and returns read data to the owner of the access.
  always_ff @(posedge sys_clock_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_BABY;
      we_q          <= 1'b0;
      starve_cnt    <= 4'd0;
      baby_gnt_o    <= 1'b0;
      baby_rvalid_o <= 1'b0;
      baby_data_o   <= '0;
      spi_gnt_o     <= 1'b0;
      spi_rvalid_o  <= 1'b0;
      spi_data_o    <= '0;
      ram_we_o      <= 1'b0;
      ram_addr_o    <= '0;
      ram_data_o    <= '0;
      busy_o        <= 1'b0;
    end else begin
      // Pulses default low; they are only raised for a single cycle.
      baby_gnt_o    <= 1'b0;
      spi_gnt_o     <= 1'b0;
      baby_rvalid_o <= 1'b0;
      spi_rvalid_o  <= 1'b0;
      ram_we_o      <= 1'b0;

      case (state_q)
        ST_IDLE, ST_RESP: begin
          // Return read data of the access that just completed.
          if (state_q == ST_RESP && !we_q) begin
            if (owner_q == OWN_BABY) begin
              baby_data_o   <= ram_data_i;
              baby_rvalid_o <= 1'b1;
            end else begin
              spi_data_o   <= ram_data_i;
              spi_rvalid_o <= 1'b1;
            end
          end

          // Starvation tracking: count SPI losses, clear on SPI win or idle.
          if (!spi_req_i || spi_wins) begin
            starve_cnt <= 4'd0;
          end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
          end

          if (any_req) begin
            state_q    <= ST_ACCESS;
            owner_q    <= spi_wins ? OWN_SPI : OWN_BABY;
            we_q       <= sel_we;
            ram_we_o   <= sel_we;
            ram_addr_o <= sel_addr;
            ram_data_o <= sel_data;
            baby_gnt_o <= ~spi_wins;
            spi_gnt_o  <= spi_wins;
            busy_o     <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
          end
        end

        ST_ACCESS: begin
          // RAM samples the address this cycle; data arrives in RESP.
          state_q <= ST_RESP;
          busy_o  <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Testbench for shared_ram_arbiter: RAM model, requester drivers, a cycle
// scoreboard that predicts grants/read data from the arbitration rules, and
// directed plus randomized scenarios.

module tb_shared_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        baby_halt_i = 1'b0;
  logic        baby_req_i = 1'b0;
  logic        baby_we_i = 1'b0;
  logic [4:0]  baby_addr_i = '0;
  logic [31:0] baby_data_i = '0;
  logic        baby_gnt_o, baby_rvalid_o;
  logic [31:0] baby_data_o;
  logic        spi_req_i = 1'b0;
  logic        spi_we_i = 1'b0;
  logic [4:0]  spi_addr_i = '0;
  logic [31:0] spi_data_i = '0;
  logic        spi_gnt_o, spi_rvalid_o;
  logic [31:0] spi_data_o;
  logic        ram_we_o;
  logic [4:0]  ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i = '0;
  logic        busy_o;
  logic [1:0]  dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shared_ram_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .sys_clock_i(clk), .rst_i(rst_i), .baby_halt_i(baby_halt_i),
    .baby_req_i(baby_req_i), .baby_we_i(baby_we_i), .baby_addr_i(baby_addr_i),
    .baby_data_i(baby_data_i), .baby_gnt_o(baby_gnt_o), .baby_rvalid_o(baby_rvalid_o),
    .baby_data_o(baby_data_o), .spi_req_i(spi_req_i), .spi_we_i(spi_we_i),
    .spi_addr_i(spi_addr_i), .spi_data_i(spi_data_i), .spi_gnt_o(spi_gnt_o),
    .spi_rvalid_o(spi_rvalid_o), .spi_data_o(spi_data_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- RAM model (1-cycle read latency) ----------------
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
    ram_data_i <= mem[ram_addr_o];
  end

  // ---------------- observation counters / grant log ----------------
  int we_cnt = 0, brv_cnt = 0, srv_cnt = 0;
  bit glog[$];   // 0 = Baby grant, 1 = SPI grant
  always @(negedge clk) begin
    if (!rst_i) begin
      if (ram_we_o)      we_cnt  = we_cnt + 1;
      if (baby_rvalid_o) brv_cnt = brv_cnt + 1;
      if (spi_rvalid_o)  srv_cnt = srv_cnt + 1;
      if (baby_gnt_o)    glog.push_back(1'b0);
      if (spi_gnt_o)     glog.push_back(1'b1);
    end
  end

  // ---------------- scoreboard / reference model ----------------
  // Rules: a cycle that is not a grant cycle is an arbitration point; the
  // winner of the arbitration in cycle c is granted in c+1; read data
  // appears two cycles after the grant; busy covers the grant cycle and the
  // one after it.
  logic [31:0] mem_m [32];
  logic [31:0] bexp_q[$];
  logic [31:0] sexp_q[$];
  bit          prev_valid = 0, prev_gnt_exp = 0;
  bit          pb, ps, ph;
  int          starve_m = 0;
  bit [1:0]    rv_b = 0, rv_s = 0;

  always @(negedge clk) begin
    bit eb, es, wspi, ewe;
    logic [31:0] d;
    if (rst_i) begin
      prev_valid = 0; prev_gnt_exp = 0; starve_m = 0; rv_b = 0; rv_s = 0;
      bexp_q.delete(); sexp_q.delete();
    end else begin
      eb = 0; es = 0;
      if (prev_valid && !prev_gnt_exp) begin
        wspi = ps && (!pb || ph || starve_m >= 4);
        es = wspi;
        eb = pb && !wspi;
        if (!ps || wspi) starve_m = 0;
        else if (starve_m < 15) starve_m = starve_m + 1;
      end
      n_tests++;
      if (baby_gnt_o !== eb || spi_gnt_o !== es) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL sb_grant cyc=%0d got b=%b s=%b exp b=%b s=%b", cyc, baby_gnt_o, spi_gnt_o, eb, es);
      end
      ewe = (eb && baby_we_i) || (es && spi_we_i);
      n_tests++;
      if (ram_we_o !== ewe) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL sb_ram_we cyc=%0d got=%b exp=%b", cyc, ram_we_o, ewe);
      end
      if (eb || es) begin
        n_tests++;
        if (ram_addr_o !== (es ? spi_addr_i : baby_addr_i)) begin
          n_fail++;
          if (n_fail < 40) $display("FAIL sb_ram_addr cyc=%0d got=%0d exp=%0d", cyc, ram_addr_o, es ? spi_addr_i : baby_addr_i);
        end
        if (ewe) begin
          n_tests++;
          if (ram_data_o !== (es ? spi_data_i : baby_data_i)) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL sb_ram_wdata cyc=%0d got=%h exp=%h", cyc, ram_data_o, es ? spi_data_i : baby_data_i);
          end
        end
      end
      n_tests++;
      if (busy_o !== (eb || es || prev_gnt_exp)) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL sb_busy cyc=%0d got=%b exp=%b", cyc, busy_o, eb || es || prev_gnt_exp);
      end
      n_tests++;
      if (baby_rvalid_o !== rv_b[1] || spi_rvalid_o !== rv_s[1]) begin
        n_fail++;
        if (n_fail < 40) $display("FAIL sb_rvalid cyc=%0d got b=%b s=%b exp b=%b s=%b", cyc, baby_rvalid_o, spi_rvalid_o, rv_b[1], rv_s[1]);
      end
      if (baby_rvalid_o === 1'b1 && bexp_q.size() > 0) begin
        d = bexp_q.pop_front();
        n_tests++;
        if (baby_data_o !== d) begin
          n_fail++;
          if (n_fail < 40) $display("FAIL sb_baby_rdata cyc=%0d got=%h exp=%h", cyc, baby_data_o, d);
        end
      end
      if (spi_rvalid_o === 1'b1 && sexp_q.size() > 0) begin
        d = sexp_q.pop_front();
        n_tests++;
        if (spi_data_o !== d) begin
          n_fail++;
          if (n_fail < 40) $display("FAIL sb_spi_rdata cyc=%0d got=%h exp=%h", cyc, spi_data_o, d);
        end
      end
      // Apply the granted transaction to the model memory.
      if (eb) begin
        if (baby_we_i) mem_m[baby_addr_i] = baby_data_i;
        else bexp_q.push_back(mem_m[baby_addr_i]);
      end
      if (es) begin
        if (spi_we_i) mem_m[spi_addr_i] = spi_data_i;
        else sexp_q.push_back(mem_m[spi_addr_i]);
      end
      rv_b = {rv_b[0], eb && !baby_we_i};
      rv_s = {rv_s[0], es && !spi_we_i};
      prev_gnt_exp = eb || es;
      pb = baby_req_i; ps = spi_req_i; ph = baby_halt_i;
      prev_valid = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Call aligned just after a rising edge; returns just after the edge
  // following the grant with req dropped.
  task automatic drive_baby(input logic we, input logic [4:0] addr, input logic [31:0] data);
    int t;
    bit got;
    baby_we_i = we; baby_addr_i = addr; baby_data_i = data; baby_req_i = 1'b1;
    got = 0; t = 0;
    while (!got && t < 400) begin
      @(negedge clk);
      if (baby_gnt_o === 1'b1) got = 1;
      t++;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL baby_gnt_timeout cyc=%0d got=no_grant exp=grant", cyc);
    end
    tick();
    baby_req_i = 1'b0;
  endtask

  task automatic drive_spi(input logic we, input logic [4:0] addr, input logic [31:0] data);
    int t;
    bit got;
    spi_we_i = we; spi_addr_i = addr; spi_data_i = data; spi_req_i = 1'b1;
    got = 0; t = 0;
    while (!got && t < 400) begin
      @(negedge clk);
      if (spi_gnt_o === 1'b1) got = 1;
      t++;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL spi_gnt_timeout cyc=%0d got=no_grant exp=grant", cyc);
    end
    tick();
    spi_req_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_tests++;
    if ({baby_gnt_o, baby_rvalid_o, baby_data_o, spi_gnt_o, spi_rvalid_o, spi_data_o,
         ram_we_o, ram_addr_o, ram_data_o, busy_o, dbg_state_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b state=%0d we=%b exp all zero", busy_o, dbg_state_o, ram_we_o);
    end
    tick();
    rst_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_baby_read();
    mem[5] = 32'hDEADBEEF; mem_m[5] = 32'hDEADBEEF;
    tick();
    baby_we_i = 1'b0; baby_addr_i = 5'd5; baby_req_i = 1'b1;
    @(negedge clk);  // cycle N
    n_tests++;
    if (baby_gnt_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL t1_cycle_n got gnt=%b busy=%b exp 0 0", baby_gnt_o, busy_o);
    end
    @(negedge clk);  // N+1
    n_tests++;
    if (baby_gnt_o !== 1'b1 || ram_addr_o !== 5'd5 || ram_we_o !== 1'b0) begin
      n_fail++; $display("FAIL t1_grant got gnt=%b addr=%0d we=%b exp 1 5 0", baby_gnt_o, ram_addr_o, ram_we_o);
    end
    tick();
    baby_req_i = 1'b0;
    @(negedge clk);  // N+2
    n_tests++;
    if (baby_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL t1_rvalid_early got=%b exp=0", baby_rvalid_o);
    end
    @(negedge clk);  // N+3
    n_tests++;
    if (baby_rvalid_o !== 1'b1 || baby_data_o !== 32'hDEADBEEF || spi_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL t1_rdata got rv=%b data=%h exp rv=1 data=deadbeef", baby_rvalid_o, baby_data_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_spi_write_read();
    int w0, r0, t;
    tick();
    w0 = we_cnt; r0 = srv_cnt;
    drive_spi(1'b1, 5'd31, 32'h12345678);
    repeat (4) @(negedge clk);
    n_tests++;
    if (we_cnt - w0 != 1 || srv_cnt != r0) begin
      n_fail++; $display("FAIL t2_write got we_pulses=%0d rvalids=%0d exp 1 0", we_cnt - w0, srv_cnt - r0);
    end
    tick();
    drive_spi(1'b0, 5'd31, 32'h0);
    t = 0;
    while (srv_cnt == r0 && t < 10) begin @(negedge clk); t++; end
    n_tests++;
    if (srv_cnt == r0 || spi_data_o !== 32'h12345678) begin
      n_fail++; $display("FAIL t2_readback got rvalids=%0d data=%h exp 1 12345678", srv_cnt - r0, spi_data_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_starvation();
    bit exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit ok;
    baby_halt_i = 1'b0;
    tick();
    glog.delete();
    fork
      begin for (int i = 0; i < 8; i++) drive_baby(1'b0, 5'(i), 32'h0); end
      begin for (int j = 0; j < 2; j++) drive_spi(1'b0, 5'(j + 10), 32'h0); end
    join
    repeat (4) tick();
    ok = (glog.size() == 10);
    if (ok) for (int k = 0; k < 10; k++) if (glog[k] != exp_seq[k]) ok = 0;
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL t3_grant_order got %0d grants first=%0d exp BBBBSBBBBS", glog.size(), glog.size() > 0 ? glog[0] : 0);
    end
  endtask

  task automatic test_halt_priority();
    bit exp_seq[5] = '{1, 1, 1, 1, 0};
    bit ok;
    baby_halt_i = 1'b1;
    tick();
    glog.delete();
    fork
      drive_baby(1'b0, 5'd3, 32'h0);
      begin for (int j = 0; j < 4; j++) drive_spi(1'b0, 5'(j), 32'h0); end
    join
    repeat (4) tick();
    ok = (glog.size() == 5);
    if (ok) for (int k = 0; k < 5; k++) if (glog[k] != exp_seq[k]) ok = 0;
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL t4_halted_order got %0d grants exp SSSSB", glog.size());
    end
    baby_halt_i = 1'b0;
  endtask

  task automatic test_reset_abort();
    int r0;
    tick();
    r0 = brv_cnt;
    baby_we_i = 1'b1; baby_addr_i = 5'd7; baby_data_i = mem_m[7]; baby_req_i = 1'b1;
    tick();             // now in ACCESS
    rst_i = 1'b1; baby_req_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (baby_gnt_o !== 1'b1 || ram_we_o !== 1'b1 || dbg_state_o !== 2'd1) begin
      n_fail++; $display("FAIL t5_in_access got gnt=%b we=%b state=%0d exp 1 1 1", baby_gnt_o, ram_we_o, dbg_state_o);
    end
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({baby_gnt_o, baby_rvalid_o, baby_data_o, spi_gnt_o, spi_rvalid_o, spi_data_o,
         ram_we_o, ram_addr_o, ram_data_o, busy_o, dbg_state_o} !== '0) begin
      n_fail++; $display("FAIL t5_after_reset got we=%b busy=%b state=%0d exp all zero", ram_we_o, busy_o, dbg_state_o);
    end
    glog.delete();
    repeat (4) tick();
    n_tests++;
    if (brv_cnt != r0 || glog.size() != 0) begin
      n_fail++; $display("FAIL t5_no_late_pulses got rvalids=%0d grants=%0d exp 0 0", brv_cnt - r0, glog.size());
    end
  endtask

  task automatic test_halted_ordering();
    logic [31:0] val;
    int r0, t;
    val = $urandom;
    baby_halt_i = 1'b1;
    tick();
    r0 = brv_cnt;
    glog.delete();
    fork
      drive_spi(1'b1, 5'd0, val);
      drive_baby(1'b0, 5'd0, 32'h0);
    join
    t = 0;
    while (brv_cnt == r0 && t < 10) begin @(negedge clk); t++; end
    n_tests++;
    if (brv_cnt == r0 || baby_data_o !== val || glog.size() != 2 || glog[0] != 1'b1) begin
      n_fail++; $display("FAIL t6_spi_then_baby got data=%h grants=%0d exp data=%h spi first", baby_data_o, glog.size(), val);
    end
    baby_halt_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    bit done;
    done = 0;
    tick();
    fork
      begin
        fork
          begin
            for (int i = 0; i < 60; i++) begin
              logic we; logic [4:0] a; logic [31:0] d;
              we = 1'($urandom_range(0, 1)); a = 5'($urandom_range(0, 31)); d = $urandom;
              repeat ($urandom_range(0, 2)) tick();
              drive_baby(we, a, d);
            end
          end
          begin
            for (int j = 0; j < 60; j++) begin
              logic we; logic [4:0] a; logic [31:0] d;
              we = 1'($urandom_range(0, 1)); a = 5'($urandom_range(0, 31)); d = $urandom;
              repeat ($urandom_range(0, 3)) tick();
              drive_spi(we, a, d);
            end
          end
        join
        done = 1;
      end
      begin
        while (!done) begin
          tick();
          if ($urandom_range(0, 7) == 0) baby_halt_i = 1'($urandom_range(0, 1));
        end
      end
    join
    baby_halt_i = 1'b0;
    repeat (6) tick();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      mem_m[i] = mem[i];
    end
    test_reset();
    test_baby_read();
    test_spi_write_read();
    test_starvation();
    test_halt_priority();
    test_reset_abort();
    test_halted_ordering();
    test_random();
    n_tests++;
    if (bexp_q.size() != 0 || sexp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_pending_reads got baby=%0d spi=%0d exp 0 0", bexp_q.size(), sexp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
